// File: rtl/vga_if.sv
// VGA raster bundle: pixel coordinates plus DAC timing strobes.
// The scan generator drives it; colour mapping and the DAC consume it.
interface vga_if;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       VGA_CLK;
    logic       VGA_HS;
    logic       VGA_VS;
    logic       VGA_BLANK_N;
    logic       VGA_SYNC_N;
    logic       frame_start;

    modport master (
        output DrawX, DrawY, VGA_CLK, VGA_HS, VGA_VS,
        output VGA_BLANK_N, VGA_SYNC_N, frame_start
    );

    modport slave (
        input DrawX, DrawY, VGA_CLK, VGA_HS, VGA_VS,
        input VGA_BLANK_N, VGA_SYNC_N, frame_start
    );
endinterface

// File: rtl/vga_scan_generator.sv
// 640x480@60 raster timing from a 2x pixel clock.
// Counters step every other Clk; sync/blank are registered in step with them.
module vga_scan_generator #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic  Clk,
    input  logic  Reset_n,
    vga_if.master vga
);
    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

    logic       pix_toggle;
    logic       vga_clk_q;
    logic [9:0] x_q;
    logic [9:0] y_q;
    logic [9:0] x_nxt;
    logic [9:0] y_nxt;
    logic       h_wrap;
    logic       v_wrap;
    logic       hs_q;
    logic       vs_q;
    logic       blank_n_q;
    logic       frame_q;

    // Next raster position; >= compare lets any out-of-range value wrap.
    always_comb begin
        h_wrap = (x_q >= H_LAST);
        v_wrap = (y_q >= V_LAST);
        x_nxt  = x_q;
        y_nxt  = y_q;
        if (pix_toggle) begin
            x_nxt = h_wrap ? 10'd0 : x_q + 10'd1;
            if (h_wrap) begin
                y_nxt = v_wrap ? 10'd0 : y_q + 10'd1;
            end
        end
    end

    // Pixel enable, counters and timing strobes decoded from next position.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            pix_toggle <= 1'b0;
            vga_clk_q  <= 1'b0;
            x_q        <= 10'd0;
            y_q        <= 10'd0;
            hs_q       <= 1'b1;
            vs_q       <= 1'b1;
            blank_n_q  <= 1'b1;
            frame_q    <= 1'b0;
        end else begin
            pix_toggle <= ~pix_toggle;
            vga_clk_q  <= pix_toggle;
            x_q        <= x_nxt;
            y_q        <= y_nxt;
            hs_q       <= !(x_nxt >= HS_START && x_nxt < HS_END);
            vs_q       <= !(y_nxt >= VS_START && y_nxt < VS_END);
            blank_n_q  <= (x_nxt < H_VIS) && (y_nxt < V_VIS);
            frame_q    <= pix_toggle && h_wrap && v_wrap;
        end
    end

    assign vga.DrawX       = x_q;
    assign vga.DrawY       = y_q;
    assign vga.VGA_CLK     = vga_clk_q;
    assign vga.VGA_HS      = hs_q;
    assign vga.VGA_VS      = vs_q;
    assign vga.VGA_BLANK_N = blank_n_q;
    assign vga.VGA_SYNC_N  = 1'b0;
    assign vga.frame_start = frame_q;
endmodule

// File: tb/tb_vga_scan_generator.sv
// Bench: a full-size and a shrunk-timing instance share clock and reset.
// Every cycle both are compared with an edge-count arithmetic model.
module tb_vga_scan_generator;
    logic Clk = 1'b0;
    logic Reset_n = 1'b0;

    vga_if bus_a ();
    vga_if bus_b ();

    vga_scan_generator dut_a (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .vga     (bus_a)
    );

    vga_scan_generator #(
        .H_VISIBLE (16), .H_FP (4), .H_SYNC (6), .H_BP (6),
        .V_VISIBLE (12), .V_FP (3), .V_SYNC (2), .V_BP (4)
    ) dut_b (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .vga     (bus_b)
    );

    // 50 MHz clock.
    always #10 Clk = ~Clk;

    typedef struct {
        int x;
        int y;
        int hs;
        int vs;
        int bn;
        int fs;
        int vc;
    } exp_t;

    typedef struct {
        int   k;
        exp_t e;
    } vec_t;

    int checks = 0;
    int failures = 0;
    int k = 0;

    // Expected outputs k edges after the reset edge, from the raster rules.
    function automatic exp_t model(input int kk,
                                   input int hv, input int hf,
                                   input int hsw, input int hb,
                                   input int vv, input int vf,
                                   input int vsw, input int vb);
        exp_t r;
        int ht, vt, n, p;
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        n  = kk / 2;
        p  = n % (ht * vt);
        r.x  = p % ht;
        r.y  = p / ht;
        r.hs = (r.x >= hv + hf && r.x < hv + hf + hsw) ? 0 : 1;
        r.vs = (r.y >= vv + vf && r.y < vv + vf + vsw) ? 0 : 1;
        r.bn = (r.x < hv && r.y < vv) ? 1 : 0;
        r.fs = (kk >= 2 && kk % 2 == 0 && p == 0) ? 1 : 0;
        r.vc = (kk == 0) ? 0 : (kk - 1) % 2;
        return r;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act,
                       input int want);
        checks++;
        if (act !== 32'(want)) begin
            failures++;
            $display("FAIL %s k=%0d got=%0d want=%0d", nm, k, act, want);
        end
    endtask

    task automatic check_a(input string tag, input exp_t e);
        cmp({tag, ".x"}, 32'(bus_a.DrawX), e.x);
        cmp({tag, ".y"}, 32'(bus_a.DrawY), e.y);
        cmp({tag, ".hs"}, 32'(bus_a.VGA_HS), e.hs);
        cmp({tag, ".vs"}, 32'(bus_a.VGA_VS), e.vs);
        cmp({tag, ".bn"}, 32'(bus_a.VGA_BLANK_N), e.bn);
        cmp({tag, ".fs"}, 32'(bus_a.frame_start), e.fs);
        cmp({tag, ".vclk"}, 32'(bus_a.VGA_CLK), e.vc);
        cmp({tag, ".syncn"}, 32'(bus_a.VGA_SYNC_N), 0);
    endtask

    task automatic check_b(input string tag, input exp_t e);
        cmp({tag, ".x"}, 32'(bus_b.DrawX), e.x);
        cmp({tag, ".y"}, 32'(bus_b.DrawY), e.y);
        cmp({tag, ".hs"}, 32'(bus_b.VGA_HS), e.hs);
        cmp({tag, ".vs"}, 32'(bus_b.VGA_VS), e.vs);
        cmp({tag, ".bn"}, 32'(bus_b.VGA_BLANK_N), e.bn);
        cmp({tag, ".fs"}, 32'(bus_b.frame_start), e.fs);
        cmp({tag, ".vclk"}, 32'(bus_b.VGA_CLK), e.vc);
        cmp({tag, ".syncn"}, 32'(bus_b.VGA_SYNC_N), 0);
    endtask

    // One Clk edge, then compare both instances with the model.
    task automatic step();
        @(posedge Clk);
        if (!Reset_n) k = 0;
        else k++;
        #1;
        check_a("modelA", model(k, 640, 16, 96, 48, 480, 10, 2, 33));
        check_b("modelB", model(k, 16, 4, 6, 6, 12, 3, 2, 4));
    endtask

    vec_t vecs [10];
    int   hs_low, bn_low, vs_low, pulses, last_pk, guard;

    initial begin
        vecs[0] = '{1,    '{0,   0, 1, 1, 1, 0, 0}};
        vecs[1] = '{2,    '{1,   0, 1, 1, 1, 0, 1}};
        vecs[2] = '{1279, '{639, 0, 1, 1, 1, 0, 0}};
        vecs[3] = '{1280, '{640, 0, 1, 1, 0, 0, 1}};
        vecs[4] = '{1311, '{655, 0, 1, 1, 0, 0, 0}};
        vecs[5] = '{1312, '{656, 0, 0, 1, 0, 0, 1}};
        vecs[6] = '{1503, '{751, 0, 0, 1, 0, 0, 0}};
        vecs[7] = '{1504, '{752, 0, 1, 1, 0, 0, 1}};
        vecs[8] = '{1599, '{799, 0, 1, 1, 0, 0, 0}};
        vecs[9] = '{1600, '{0,   1, 1, 1, 1, 0, 1}};

        // Reset held for four edges.
        Reset_n = 1'b0;
        repeat (4) step();
        check_a("rst", '{0, 0, 1, 1, 1, 0, 0});
        #1 Reset_n = 1'b1;

        // Table of horizontal landmarks on the full-size instance.
        for (int i = 0; i < 10; i++) begin
            while (k < vecs[i].k) step();
            check_a($sformatf("vec%0d", i), vecs[i].e);
        end

        // Measure HS and blank widths over line 1.
        hs_low = 0;
        bn_low = 0;
        while (k < 3200) begin
            step();
            if (bus_a.VGA_HS == 1'b0) hs_low++;
            if (bus_a.VGA_BLANK_N == 1'b0) bn_low++;
        end
        cmp("hs_low_width", 32'(hs_low), 192);
        cmp("blank_low_width", 32'(bn_low), 320);

        // Three small frames: frame_start count, spacing, VS width.
        pulses = 0;
        last_pk = -1;
        vs_low = 0;
        repeat (3 * 1344) begin
            step();
            if (bus_b.VGA_VS == 1'b0) vs_low++;
            if (bus_b.frame_start == 1'b1) begin
                pulses++;
                cmp("fs_at_x0", 32'(bus_b.DrawX), 0);
                cmp("fs_at_y0", 32'(bus_b.DrawY), 0);
                if (last_pk >= 0) cmp("fs_spacing", 32'(k - last_pk), 1344);
                last_pk = k;
            end
        end
        cmp("fs_pulses", 32'(pulses), 3);
        cmp("vs_low_width", 32'(vs_low), 3 * 128);

        // Reset while both syncs are low on the small instance.
        guard = 0;
        while (!(bus_b.VGA_HS == 1'b0 && bus_b.VGA_VS == 1'b0)
               && guard < 3000) begin
            step();
            guard++;
        end
        cmp("sync_wait_timeout", 32'(guard < 3000), 1);
        #1 Reset_n = 1'b0;
        step();
        check_b("midrst", '{0, 0, 1, 1, 1, 0, 0});
        #1 Reset_n = 1'b1;
        step();
        step();
        check_b("after_midrst", '{1, 0, 1, 1, 1, 0, 1});

        // Random run lengths interleaved with random resets.
        for (int it = 0; it < 20; it++) begin
            repeat ($urandom_range(2500, 1)) step();
            #1 Reset_n = 1'b0;
            repeat ($urandom_range(3, 1)) step();
            #1 Reset_n = 1'b1;
        end
        repeat (50) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
